// File: rtl/led_pkg.sv
// led_pkg: shared encodings and default tick periods for the LED pattern generator.
package led_pkg;

  // Pattern mode held by the mode FSM.
  typedef enum logic {
    MODE_SHIFT = 1'b0,
    MODE_FLASH = 1'b1
  } mode_e;

  // Direction of the walking LED in SHIFT mode.
  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

  // Default tick periods in clocks, selected by i_sw[2:1].
  localparam int unsigned LIMIT0_DEF = 32'd67108864;  // 2**26
  localparam int unsigned LIMIT1_DEF = 32'd33554432;  // 2**25
  localparam int unsigned LIMIT2_DEF = 32'd16777216;  // 2**24
  localparam int unsigned LIMIT3_DEF = 32'd8388608;   // 2**23

endpackage

// File: rtl/btn_edge.sv
// btn_edge: 2-flop synchronizer plus rising-edge detector for an asynchronous
// button. One pulse per press, visible two clocks after the input rises so the
// consuming register acts on the third edge. After reset the edge detector is
// held "armed high" until the synchronizer has refilled, so a button held
// through reset does not produce a pulse on release.
module btn_edge (
  input  logic clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_pulse
);

  logic sync1_r;
  logic sync2_r;
  logic prev_r;
  logic fill1_r;
  logic fill2_r;

  // Synchronize the button, track pipeline fill and remember the previous level.
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      prev_r  <= 1'b0;
      fill1_r <= 1'b0;
      fill2_r <= 1'b0;
    end else begin
      sync1_r <= i_btn;
      sync2_r <= sync1_r;
      fill1_r <= 1'b1;
      fill2_r <= fill1_r;
      // Until the synchronizer holds valid data, pretend the last level was high.
      prev_r  <= sync2_r | ~fill2_r;
    end
  end

  // Rising edge of the synchronized level.
  always_comb begin
    o_pulse = sync2_r & ~prev_r;
  end

endmodule

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: timed LED pattern generator with SHIFT (walking one) and
// FLASH (all on / all off) modes, button-controlled mode and direction.
// Optional build macro LED_PATTERN_PINGPONG_EN: in SHIFT the lit LED bounces
// at the ends instead of wrapping around.
module led_pattern_gen
  import led_pkg::*;
#(
  parameter int          N_LEDS = 4,
  parameter int          CNT_W  = 32,
  parameter int unsigned LIMIT0 = LIMIT0_DEF,
  parameter int unsigned LIMIT1 = LIMIT1_DEF,
  parameter int unsigned LIMIT2 = LIMIT2_DEF,
  parameter int unsigned LIMIT3 = LIMIT3_DEF
) (
  input  logic              clk,
  input  logic              i_rst_n,
  input  logic [2:0]        i_sw,
  input  logic              i_btn_mode,
  input  logic              i_btn_dir,
  output logic [N_LEDS-1:0] o_led,
  output logic              o_mode,
  output logic              o_tick
);

  localparam logic [N_LEDS-1:0] LED_LSB = {{(N_LEDS-1){1'b0}}, 1'b1};

  mode_e             mode_r;
  mode_e             mode_nxt_s;
  dir_e              dir_r;
  dir_e              dir_nxt_s;
  logic [N_LEDS-1:0] led_r;
  logic [N_LEDS-1:0] led_nxt_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  cnt_nxt_s;
  logic              tick_r;
  logic              tick_nxt_s;
  logic [CNT_W-1:0]  lim_s;
  logic              tick_s;
  logic              mode_pulse_s;
  logic              dir_pulse_s;

  function automatic logic [N_LEDS-1:0] rot_left(input logic [N_LEDS-1:0] v);
    return {v[N_LEDS-2:0], v[N_LEDS-1]};
  endfunction

  function automatic logic [N_LEDS-1:0] rot_right(input logic [N_LEDS-1:0] v);
    return {v[0], v[N_LEDS-1:1]};
  endfunction

  btn_edge u_btn_mode (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .i_btn   (i_btn_mode),
    .o_pulse (mode_pulse_s)
  );

  btn_edge u_btn_dir (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .i_btn   (i_btn_dir),
    .o_pulse (dir_pulse_s)
  );

  // Select the active period; the >= compare lets a speed change apply at once.
  always_comb begin
    case (i_sw[2:1])
      2'd0:    lim_s = CNT_W'(LIMIT0);
      2'd1:    lim_s = CNT_W'(LIMIT1);
      2'd2:    lim_s = CNT_W'(LIMIT2);
      2'd3:    lim_s = CNT_W'(LIMIT3);
      default: lim_s = CNT_W'(LIMIT0);
    endcase
    tick_s = i_sw[0] & (cnt_r >= (lim_s - CNT_W'(1)));
  end

  // Mode FSM state register.
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      mode_r <= MODE_SHIFT;
    end else begin
      mode_r <= mode_nxt_s;
    end
  end

  // Mode FSM next state: each mode pulse toggles between SHIFT and FLASH.
  always_comb begin
    if (mode_pulse_s) begin
      mode_nxt_s = (mode_r == MODE_SHIFT) ? MODE_FLASH : MODE_SHIFT;
    end else begin
      mode_nxt_s = mode_r;
    end
  end

  // Next counter, pattern, direction and tick; a mode change beats a tick.
  always_comb begin
    led_nxt_s  = led_r;
    cnt_nxt_s  = cnt_r;
    tick_nxt_s = 1'b0;
    if (dir_pulse_s) begin
      dir_nxt_s = (dir_r == DIR_LEFT) ? DIR_RIGHT : DIR_LEFT;
    end else begin
      dir_nxt_s = dir_r;
    end

    if (mode_pulse_s) begin
      cnt_nxt_s = '0;
      if (mode_nxt_s == MODE_SHIFT) begin
        led_nxt_s = LED_LSB;
        dir_nxt_s = DIR_LEFT;
      end else begin
        led_nxt_s = '1;
      end
    end else if (tick_s) begin
      cnt_nxt_s  = '0;
      tick_nxt_s = 1'b1;
      if (mode_r == MODE_FLASH) begin
        led_nxt_s = ~led_r;
      end else begin
`ifdef LED_PATTERN_PINGPONG_EN
        if ((dir_nxt_s == DIR_LEFT) && led_r[N_LEDS-1]) begin
          led_nxt_s = rot_right(led_r);
          dir_nxt_s = DIR_RIGHT;
        end else if ((dir_nxt_s == DIR_RIGHT) && led_r[0]) begin
          led_nxt_s = rot_left(led_r);
          dir_nxt_s = DIR_LEFT;
        end else if (dir_nxt_s == DIR_LEFT) begin
          led_nxt_s = rot_left(led_r);
        end else begin
          led_nxt_s = rot_right(led_r);
        end
`else
        if (dir_nxt_s == DIR_LEFT) begin
          led_nxt_s = rot_left(led_r);
        end else begin
          led_nxt_s = rot_right(led_r);
        end
`endif
      end
    end else if (i_sw[0]) begin
      cnt_nxt_s = cnt_r + CNT_W'(1);
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Datapath registers; reset overrides every other event.
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      dir_r  <= DIR_LEFT;
      led_r  <= LED_LSB;
      cnt_r  <= '0;
      tick_r <= 1'b0;
    end else begin
      dir_r  <= dir_nxt_s;
      led_r  <= led_nxt_s;
      cnt_r  <= cnt_nxt_s;
      tick_r <= tick_nxt_s;
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    o_led  = led_r;
    o_mode = mode_r;
    o_tick = tick_r;
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// tb_led_pattern_gen: table-driven directed checks of led_pattern_gen with
// N_LEDS=4 and periods 8/6/4/2. Expected values follow
// LED_PATTERN_PINGPONG_EN when it is defined.
module tb_led_pattern_gen;

`ifdef LED_PATTERN_PINGPONG_EN
  localparam bit PP = 1'b1;
`else
  localparam bit PP = 1'b0;
`endif

  logic       clk;
  logic       i_rst_n;
  logic [2:0] i_sw;
  logic       i_btn_mode;
  logic       i_btn_dir;
  logic [3:0] o_led;
  logic       o_mode;
  logic       o_tick;

  int n_checks;
  int n_fails;

  typedef struct {
    logic [2:0] sw;
    logic       bm;
    logic       bd;
    int         cyc;
    logic [3:0] led;
    logic       mode;
    logic       tick;
    string      name;
  } vec_t;

  vec_t vq[$];

  led_pattern_gen #(
    .N_LEDS (4),
    .CNT_W  (8),
    .LIMIT0 (8),
    .LIMIT1 (6),
    .LIMIT2 (4),
    .LIMIT3 (2)
  ) dut (
    .clk        (clk),
    .i_rst_n    (i_rst_n),
    .i_sw       (i_sw),
    .i_btn_mode (i_btn_mode),
    .i_btn_dir  (i_btn_dir),
    .o_led      (o_led),
    .o_mode     (o_mode),
    .o_tick     (o_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [3:0] led,
                       input logic mode, input logic tick);
    n_checks++;
    if (o_led !== led || o_mode !== mode || o_tick !== tick) begin
      n_fails++;
      $display("FAIL %s: got led=%b mode=%b tick=%b, expected led=%b mode=%b tick=%b",
               name, o_led, o_mode, o_tick, led, mode, tick);
    end
  endtask

  initial begin
    n_checks   = 0;
    n_fails    = 0;
    i_rst_n    = 1'b0;
    i_sw       = 3'b000;
    i_btn_mode = 1'b0;
    i_btn_dir  = 1'b0;

    // Shift: 0001 -> 0010 -> 0100 -> 1000 -> 0001, tick every 8 cycles
    vq.push_back('{3'b001, 1'b0, 1'b0, 7, 4'b0001, 1'b0, 1'b0, "shift_pre_tick"});
    vq.push_back('{3'b001, 1'b0, 1'b0, 1, 4'b0010, 1'b0, 1'b1, "shift_tick1"});
    vq.push_back('{3'b001, 1'b0, 1'b0, 1, 4'b0010, 1'b0, 1'b0, "tick_one_cycle"});
    vq.push_back('{3'b001, 1'b0, 1'b0, 7, 4'b0100, 1'b0, 1'b1, "shift_tick2"});
    vq.push_back('{3'b001, 1'b0, 1'b0, 8, 4'b1000, 1'b0, 1'b1, "shift_tick3"});
    vq.push_back('{3'b001, 1'b0, 1'b0, 8, 4'b0001, 1'b0, 1'b1, "shift_wrap"});
    // Mode press: takes effect on the third edge
    vq.push_back('{3'b001, 1'b1, 1'b0, 2, 4'b0001, 1'b0, 1'b0, "mode_sync_delay"});
    vq.push_back('{3'b001, 1'b0, 1'b0, 1, 4'b1111, 1'b1, 1'b0, "enter_flash"});
    vq.push_back('{3'b001, 1'b0, 1'b0, 7, 4'b1111, 1'b1, 1'b0, "flash_hold"});
    vq.push_back('{3'b001, 1'b0, 1'b0, 1, 4'b0000, 1'b1, 1'b1, "flash_off"});
    vq.push_back('{3'b001, 1'b0, 1'b0, 8, 4'b1111, 1'b1, 1'b1, "flash_on"});
    // Mode pulse coinciding with a tick: entry load wins, no tick
    vq.push_back('{3'b001, 1'b0, 1'b0, 5, 4'b1111, 1'b1, 1'b0, "coinc_wait"});
    vq.push_back('{3'b001, 1'b1, 1'b0, 2, 4'b1111, 1'b1, 1'b0, "coinc_press"});
    vq.push_back('{3'b001, 1'b0, 1'b0, 1, 4'b0001, 1'b0, 1'b0, "coinc_mode_wins"});
    vq.push_back('{3'b001, 1'b0, 1'b0, 7, 4'b0001, 1'b0, 1'b0, "coinc_cnt_zero"});
    vq.push_back('{3'b001, 1'b0, 1'b0, 1, 4'b0010, 1'b0, 1'b1, "coinc_next_tick"});
    // Fast speed, direction press while disabled and sitting at 0001
    vq.push_back('{3'b111, 1'b0, 1'b0, 6, 4'b0001, 1'b0, 1'b1, "fast_to_0001"});
    vq.push_back('{3'b110, 1'b0, 1'b1, 2, 4'b0001, 1'b0, 1'b0, "dir_press_idle"});
    vq.push_back('{3'b110, 1'b0, 1'b0, 1, 4'b0001, 1'b0, 1'b0, "dir_toggled_idle"});
    vq.push_back('{3'b111, 1'b0, 1'b0, 1, 4'b0001, 1'b0, 1'b0, "fast_count"});
    vq.push_back('{3'b111, 1'b0, 1'b0, 1, PP ? 4'b0010 : 4'b1000, 1'b0, 1'b1, "dir_right_lsb_edge"});
    vq.push_back('{3'b111, 1'b0, 1'b0, 2, 4'b0100, 1'b0, 1'b1, "after_lsb_edge"});
    // Freeze for 20 cycles mid-count, then the remaining count
    vq.push_back('{3'b011, 1'b0, 1'b0, 3, 4'b0100, 1'b0, 1'b0, "mid_count"});
    vq.push_back('{3'b010, 1'b0, 1'b0, 20, 4'b0100, 1'b0, 1'b0, "frozen"});
    vq.push_back('{3'b011, 1'b0, 1'b0, 2, 4'b0100, 1'b0, 1'b0, "resume_no_tick"});
    vq.push_back('{3'b011, 1'b0, 1'b0, 1, PP ? 4'b1000 : 4'b0010, 1'b0, 1'b1, "resume_tick"});
    // Speed change mid-count: >= compare fires immediately
    vq.push_back('{3'b011, 1'b0, 1'b0, 4, PP ? 4'b1000 : 4'b0010, 1'b0, 1'b0, "slow_count4"});
    vq.push_back('{3'b111, 1'b0, 1'b0, 1, PP ? 4'b0100 : 4'b0001, 1'b0, 1'b1, "speed_change_tick"});

    cycles(3);
    check("reset_state", 4'b0001, 1'b0, 1'b0);
    i_rst_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      i_sw       = vq[i].sw;
      i_btn_mode = vq[i].bm;
      i_btn_dir  = vq[i].bd;
      cycles(vq[i].cyc);
      check(vq[i].name, vq[i].led, vq[i].mode, vq[i].tick);
    end

    // Reset during FLASH with the mode button held
    i_sw       = 3'b000;
    i_btn_dir  = 1'b0;
    i_btn_mode = 1'b1;
    cycles(3);
    check("held_enter_flash", 4'b1111, 1'b1, 1'b0);
    cycles(2);
    i_rst_n = 1'b0;
    cycles(2);
    check("reset_in_flash", 4'b0001, 1'b0, 1'b0);
    i_rst_n = 1'b1;
    cycles(10);
    check("no_spurious_toggle", 4'b0001, 1'b0, 1'b0);
    i_btn_mode = 1'b0;
    cycles(3);
    i_btn_mode = 1'b1;
    cycles(3);
    check("repress_toggles", 4'b1111, 1'b1, 1'b0);
    i_btn_mode = 1'b0;
    cycles(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
